// File: rtl/sema_bank_arbiter.sv
// sema_bank_arbiter: shares one semaphore bank port between N_CORES CPUs.
// Requests are granted round-robin, one bank access at a time, in the
// sequence IDLE -> ISSUE -> CAPT -> IDLE.
// Waiting cores are held through suspend until their ack pulse arrives.
// Optional feature macro: SEMA_ARB_LOCK_EN adds a per-core lock input.
// The lock keeps the arbiter on one core so that it can complete an atomic
// read-modify-write sequence.
module sema_bank_arbiter #(
   parameter int  N_CORES = 4,
   parameter int  N_SEMA  = 16,
   parameter int  DW      = 16,
   localparam int AW      = $clog2(N_SEMA)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [N_CORES-1:0]    req,
   input  logic [N_CORES-1:0]    we,
   input  logic [N_CORES*AW-1:0] addr,
   input  logic [N_CORES*DW-1:0] wdata,
   output logic [N_CORES-1:0]    ack,
   output logic [DW-1:0]         rdata,
   output logic [N_CORES-1:0]    suspend,
   output logic                  bank_en,
   output logic                  bank_we,
   output logic [AW-1:0]         bank_addr,
   output logic [DW-1:0]         bank_wdata,
   input  logic [DW-1:0]         bank_rdata
`ifdef SEMA_ARB_LOCK_EN
   ,
   input  logic [N_CORES-1:0]    lock
`endif
);

   localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      CAPT  = 2'd2
   } state_t;

   state_t           state_r;
   logic [IW-1:0]    gnt_id_r;
   logic [IW-1:0]    rr_ptr_r;
   logic             we_r;
   logic [N_CORES-1:0] eff_req_s;
   logic [IW-1:0]    rr_idx_s;
   logic             rr_found_s;
   logic [IW-1:0]    rr_id_s;
   logic             sel_found_s;
   logic [IW-1:0]    sel_id_s;
`ifdef SEMA_ARB_LOCK_EN
   logic             lock_act_r;
`endif

   // The core being acked this cycle still holds req; it must not win again.
   assign eff_req_s = req & ~ack;

   // A core stays stalled from its request until the cycle of its ack.
   assign suspend = req & ~ack;

   // Round-robin search: first pending core after the last granted one.
   always_comb begin
      rr_found_s = 1'b0;
      rr_id_s    = {IW{1'b0}};
      rr_idx_s   = {IW{1'b0}};
      for (int i = 1; i <= N_CORES; i++) begin
         rr_idx_s = IW'((32'(rr_ptr_r) + i) % N_CORES);
         if (!rr_found_s && eff_req_s[rr_idx_s]) begin
            rr_found_s = 1'b1;
            rr_id_s    = rr_idx_s;
         end else begin
            rr_found_s = rr_found_s;
         end
      end
   end

   // Winner choice: round-robin, or the locked core while a lock is held.
   always_comb begin
      sel_found_s = rr_found_s;
      sel_id_s    = rr_id_s;
`ifdef SEMA_ARB_LOCK_EN
      if (lock_act_r && req[gnt_id_r]) begin
         // Locked owner: wait out its ack cycle, then serve its next access.
         sel_found_s = ~ack[gnt_id_r];
         sel_id_s    = gnt_id_r;
      end else begin
         sel_found_s = rr_found_s;
         sel_id_s    = rr_id_s;
      end
`endif
   end

   // Access sequencer: grant, single-cycle bank strobe, capture and ack.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r    <= IDLE;
         gnt_id_r   <= {IW{1'b0}};
         rr_ptr_r   <= IW'(N_CORES - 1);
         we_r       <= 1'b0;
         ack        <= {N_CORES{1'b0}};
         rdata      <= {DW{1'b0}};
         bank_en    <= 1'b0;
         bank_we    <= 1'b0;
         bank_addr  <= {AW{1'b0}};
         bank_wdata <= {DW{1'b0}};
`ifdef SEMA_ARB_LOCK_EN
         lock_act_r <= 1'b0;
`endif
      end else begin
         ack <= {N_CORES{1'b0}};
         case (state_r)
            IDLE: begin
`ifdef SEMA_ARB_LOCK_EN
               if (lock_act_r && !req[gnt_id_r]) begin
                  lock_act_r <= 1'b0;
               end
`endif
               if (sel_found_s) begin
                  gnt_id_r   <= sel_id_s;
                  we_r       <= we[sel_id_s];
                  bank_en    <= 1'b1;
                  bank_we    <= we[sel_id_s];
                  bank_addr  <= addr[32'(sel_id_s)*AW +: AW];
                  bank_wdata <= wdata[32'(sel_id_s)*DW +: DW];
                  state_r    <= ISSUE;
               end else begin
                  state_r <= IDLE;
               end
            end
            ISSUE: begin
               bank_en <= 1'b0;
               bank_we <= 1'b0;
               state_r <= CAPT;
            end
            CAPT: begin
               rdata    <= we_r ? {DW{1'b0}} : bank_rdata;
               ack      <= {{(N_CORES-1){1'b0}}, 1'b1} << gnt_id_r;
               rr_ptr_r <= gnt_id_r;
`ifdef SEMA_ARB_LOCK_EN
               lock_act_r <= lock[gnt_id_r];
`endif
               state_r  <= IDLE;
            end
            default: begin
               bank_en <= 1'b0;
               bank_we <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sema_bank_arbiter.sv
// Testbench for sema_bank_arbiter.
// The directed phases cover reset, a single read, a drop during issue, a
// drop before grant, reset during issue and (with SEMA_ARB_LOCK_EN) the lock.
// The random phase issues per-core requests into a scoreboard.
// A monitor predicts grant order and timing from the round-robin rules.
module tb_sema_bank_arbiter;
   localparam int N  = 4;
   localparam int NS = 16;
   localparam int DW = 16;
   localparam int AW = 4;

   typedef logic [DW-1:0] mem_t [NS];

   function automatic mem_t init_mem();
      mem_t m;
      for (int a = 0; a < NS; a++) m[a] = DW'(32'h0100 + a);
      m[3] = 16'h00A5;
      return m;
   endfunction

   logic            clk   = 1'b0;
   logic            rstn  = 1'b0;
   logic [N-1:0]    req   = '0;
   logic [N-1:0]    we    = '0;
   logic [N*AW-1:0] addr  = '0;
   logic [N*DW-1:0] wdata = '0;
   logic [N-1:0]    ack;
   logic [DW-1:0]   rdata;
   logic [N-1:0]    suspend;
   logic            bank_en;
   logic            bank_we;
   logic [AW-1:0]   bank_addr;
   logic [DW-1:0]   bank_wdata;
   logic [DW-1:0]   bank_rdata = '0;
`ifdef SEMA_ARB_LOCK_EN
   logic [N-1:0]    lock_tb = '0;
`endif

   mem_t bank_mem = init_mem();
   mem_t ref_mem  = init_mem();

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit model_on = 1'b0;
   int rel_cyc  = 0;
   int issued [N] = '{default: 0};
   int served [N] = '{default: 0};
   int elig   [N] = '{default: 0};
   logic [DW-1:0] exp_q [N][$];

   sema_bank_arbiter #(.N_CORES(N), .N_SEMA(NS), .DW(DW)) dut (
      .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .rdata(rdata), .suspend(suspend), .bank_en(bank_en),
      .bank_we(bank_we), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
      .bank_rdata(bank_rdata)
`ifdef SEMA_ARB_LOCK_EN
      , .lock(lock_tb)
`endif
   );

   always #5 clk = ~clk;

   // Cycle counter: counts rising edges.
   always @(posedge clk) cyc <= cyc + 1;

   // Bank model: synchronous write, read data one cycle after the strobe.
   always @(posedge clk) begin
      if (bank_en) begin
         if (bank_we) bank_mem[bank_addr] <= bank_wdata;
         else         bank_rdata <= bank_mem[bank_addr];
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   task automatic drive(input int i, input logic w, input int a, input logic [DW-1:0] d);
      req[i] = 1'b1;
      we[i]  = w;
      addr[i*AW +: AW]  = AW'(a);
      wdata[i*DW +: DW] = d;
   endtask

   // Issue into the scoreboard; each core owns addresses a with a % N == i.
   task automatic issue_m(input int i, input logic w, input int a, input logic [DW-1:0] d, input int el);
      drive(i, w, a, d);
      if (w) begin
         ref_mem[a] = d;
         exp_q[i].push_back('0);
      end else begin
         exp_q[i].push_back(ref_mem[a]);
      end
      elig[i] = el;
      issued[i]++;
   endtask

   function automatic bit all_served();
      bit r = 1'b1;
      for (int i = 0; i < N; i++) if (issued[i] != served[i]) r = 1'b0;
      return r;
   endfunction

   task automatic drive_cycles(input int n, input bit allow_new);
      repeat (n) begin
         @(negedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (issued[i] == served[i]) begin
               if (req[i]) begin
                  // Just acked: either re-request at once or drop req.
                  if (allow_new && $urandom_range(0, 1) == 1)
                     issue_m(i, 1'($urandom_range(0, 1)), i + N * int'($urandom_range(0, NS/N - 1)),
                             DW'($urandom), cyc + 2);
                  else
                     req[i] = 1'b0;
               end else if (allow_new && $urandom_range(0, 2) == 0) begin
                  issue_m(i, 1'($urandom_range(0, 1)), i + N * int'($urandom_range(0, NS/N - 1)),
                          DW'($urandom), cyc + 1);
               end
            end
         end
      end
   endtask

   // Monitor: predicts the next grant edge and winner from pending requests.
   always @(negedge clk) begin : monitor
      int   best, g, win, j, last_ack_cyc, last_id;
      bit   any_p, started;
      logic [N-1:0]  exp_ack;
      logic [DW-1:0] exp_rd;
      if (model_on) begin
         if (!started) begin
            started      = 1'b1;
            last_ack_cyc = rel_cyc;
            last_id      = N - 1;
         end
         exp_ack = '0;
         any_p   = 1'b0;
         best    = 32'h7fffffff;
         win     = -1;
         for (int i = 0; i < N; i++) begin
            if (issued[i] != served[i]) begin
               any_p = 1'b1;
               if (elig[i] < best) best = elig[i];
            end
         end
         if (any_p) begin
            g = (last_ack_cyc + 1 > best) ? last_ack_cyc + 1 : best;
            for (int k = 1; k <= N; k++) begin
               j = (last_id + k) % N;
               if (win < 0 && issued[j] != served[j] && elig[j] <= g) win = j;
            end
            if (cyc == g + 2 && win >= 0) exp_ack = N'(1) << win;
         end
         check("ack", 32'(ack), 32'(exp_ack));
         check("suspend", 32'(suspend), 32'(req & ~exp_ack));
         if (exp_ack != '0) begin
            exp_rd = exp_q[win].pop_front();
            check("rdata", 32'(rdata), 32'(exp_rd));
            served[win]++;
            last_ack_cyc = cyc;
            last_id      = win;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      bit done;
      repeat (3) @(negedge clk);
      check("rst_ack", 32'(ack), 32'h0);
      check("rst_rdata", 32'(rdata), 32'h0);
      check("rst_bank_en", 32'(bank_en), 32'h0);
      check("rst_bank_we", 32'(bank_we), 32'h0);
      check("rst_bank_addr", 32'(bank_addr), 32'h0);
      check("rst_bank_wdata", 32'(bank_wdata), 32'h0);
      check("rst_suspend", 32'(suspend), 32'h0);
      rstn = 1'b1;
      @(negedge clk);

      // Single read from core 0.
      drive(0, 1'b0, 3, '0);
      #1 check("t1_susp_k", 32'(suspend), 32'h1);
      @(negedge clk);
      check("t1_bank_en", 32'(bank_en), 32'h1);
      check("t1_bank_addr", 32'(bank_addr), 32'h3);
      check("t1_bank_we", 32'(bank_we), 32'h0);
      check("t1_ack_early", 32'(ack), 32'h0);
      @(negedge clk);
      check("t1_bank_en_1cyc", 32'(bank_en), 32'h0);
      check("t1_susp", 32'(suspend), 32'h1);
      @(negedge clk);
      check("t1_ack", 32'(ack), 32'h1);
      check("t1_rdata", 32'(rdata), 32'h00A5);
      check("t1_susp_ack", 32'(suspend), 32'h0);
      req[0] = 1'b0;
      @(negedge clk);
      check("t1_ack_pulse", 32'(ack), 32'h0);

      // Core 1 write, req dropped during ISSUE.
      drive(1, 1'b1, 5, 16'hBEEF);
      @(negedge clk);
      check("t4_bank_en", 32'(bank_en), 32'h1);
      check("t4_bank_we", 32'(bank_we), 32'h1);
      check("t4_bank_wdata", 32'(bank_wdata), 32'hBEEF);
      req[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("t4_ack", 32'(ack), 32'h2);
      check("t4_rdata_wr", 32'(rdata), 32'h0);
      check("t4_mem", 32'(bank_mem[5]), 32'hBEEF);
      ref_mem[5] = 16'hBEEF;
      @(negedge clk);
      check("t4_ack_pulse", 32'(ack), 32'h0);

      // Core 2 request withdrawn before it could be granted.
      drive(0, 1'b0, 0, '0);
      @(negedge clk);
      drive(2, 1'b1, 2, 16'hDEAD);
      @(negedge clk);
      req[2] = 1'b0;
      @(negedge clk);
      check("drop_ack0", 32'(ack), 32'h1);
      check("drop_rdata", 32'(rdata), 32'(ref_mem[0]));
      req[0] = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("drop_no_bank_en", 32'(bank_en), 32'h0);
         check("drop_no_ack", 32'(ack), 32'h0);
      end
      check("drop_mem", 32'(bank_mem[2]), 32'(ref_mem[2]));

      // Reset during ISSUE, then a contended grant (core 2 last was core 0).
      drive(2, 1'b0, 6, '0);
      @(negedge clk);
      check("t5_bank_en", 32'(bank_en), 32'h1);
      #1 rstn = 1'b0;
      #1;
      check("t5_rst_bank_en", 32'(bank_en), 32'h0);
      check("t5_rst_ack", 32'(ack), 32'h0);
      check("t5_rst_rdata", 32'(rdata), 32'h0);
      req = '0;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      drive(0, 1'b0, 0, '0);
      drive(2, 1'b0, 2, '0);
      repeat (3) @(negedge clk);
      check("t5_first_core0", 32'(ack), 32'h1);
      check("t5_rdata0", 32'(rdata), 32'(ref_mem[0]));
      req[0] = 1'b0;
      repeat (3) @(negedge clk);
      check("t5_then_core2", 32'(ack), 32'h4);
      check("t5_rdata2", 32'(rdata), 32'(ref_mem[2]));
      req[2] = 1'b0;
      @(negedge clk);

      // Scoreboard phase, starting from reset: all four cores write at once.
      rstn = 1'b0;
      @(negedge clk);
      rstn     = 1'b1;
      rel_cyc  = cyc;
      model_on = 1'b1;
      #1;
      for (int i = 0; i < N; i++) issue_m(i, 1'b1, i, DW'(16'h0010 + i), cyc + 1);
      drive_cycles(14, 1'b0);
      for (int i = 0; i < N; i++) check("t2_mem", 32'(bank_mem[i]), 32'h10 + i);
      drive_cycles(400, 1'b1);
      done = 1'b0;
      for (int t = 0; t < 100 && !done; t++) begin
         drive_cycles(1, 1'b0);
         done = all_served();
      end
      check("drain", 32'(done), 32'h1);
      drive_cycles(2, 1'b0);
      model_on = 1'b0;
      for (int a = 0; a < NS; a++) check("final_mem", 32'(bank_mem[a]), 32'(ref_mem[a]));

`ifdef SEMA_ARB_LOCK_EN
      // Locked read-modify-write by core 3 while core 0 keeps requesting.
      @(negedge clk);
      lock_tb[3] = 1'b1;
      drive(3, 1'b0, 7, '0);
      @(negedge clk);
      drive(0, 1'b0, 0, '0);
      check("lk_bank_en", 32'(bank_en), 32'h1);
      check("lk_bank_addr", 32'(bank_addr), 32'h7);
      @(negedge clk);
      @(negedge clk);
      check("lk_ack_rd", 32'(ack), 32'h8);
      check("lk_rdata", 32'(rdata), 32'(ref_mem[7]));
      lock_tb[3] = 1'b0;
      drive(3, 1'b1, 7, 16'h5A5A);
      ref_mem[7] = 16'h5A5A;
      @(negedge clk);
      check("lk_wait_ack", 32'(ack), 32'h0);
      check("lk_susp0", 32'(suspend[0]), 32'h1);
      @(negedge clk);
      check("lk_wr_bank_en", 32'(bank_en), 32'h1);
      check("lk_wr_bank_addr", 32'(bank_addr), 32'h7);
      check("lk_wr_bank_we", 32'(bank_we), 32'h1);
      @(negedge clk);
      @(negedge clk);
      check("lk_ack_wr", 32'(ack), 32'h8);
      req[3] = 1'b0;
      @(negedge clk);
      check("lk_c0_bank_en", 32'(bank_en), 32'h1);
      check("lk_c0_bank_addr", 32'(bank_addr), 32'h0);
      @(negedge clk);
      @(negedge clk);
      check("lk_ack_c0", 32'(ack), 32'h1);
      check("lk_mem", 32'(bank_mem[7]), 32'h5A5A);
      req[0] = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
